// File: rtl/ddr_rd_burst_checker.sv
// Checks one DDR3 read burst of BEATS words against base_pattern + beat index,
// replicated across every 32-bit lane. Counts mismatching beats, captures the
// first failing word, flags no-data timeouts and emits a heartbeat trigger.
module ddr_rd_burst_checker #(
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned BEATS   = 4,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned ERR_W   = 16,
   localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       base_pattern,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_ready,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [BW-1:0]     first_err_beat,
   output logic [DATA_W-1:0] data_out,
   output logic              r_led,
   output logic              trigger
);

   localparam int unsigned LANES = DATA_W / 32;
   localparam int unsigned TW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [BW-1:0]       beat_q, beat_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [31:0]         base_q, base_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [BW-1:0]       feb_q, feb_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                timeout_q, timeout_d;
   logic [CNT_W-1:0]    hb_q, hb_d;
   logic                trig_q, trig_d;
   logic                r_led_q;

   logic [31:0]         exp_lane;
   logic [DATA_W-1:0]   exp_word;

   assign exp_lane = base_q + 32'(beat_q);
   assign exp_word = {LANES{exp_lane}};

   // State and result registers; synchronous active-low reset clears everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         beat_q     <= '0;
         timer_q    <= '0;
         base_q     <= '0;
         err_q      <= '0;
         feb_q      <= '0;
         data_out_q <= '0;
         timeout_q  <= 1'b0;
         hb_q       <= '0;
         trig_q     <= 1'b0;
         r_led_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         timer_q    <= timer_d;
         base_q     <= base_d;
         err_q      <= err_d;
         feb_q      <= feb_d;
         data_out_q <= data_out_d;
         timeout_q  <= timeout_d;
         hb_q       <= hb_d;
         trig_q     <= trig_d;
         r_led_q    <= 1'b1;
      end
   end

   // Heartbeat: free-running counter, trigger registered one cycle after all-ones.
   always_comb begin
      hb_d   = hb_q + 1'b1;
      trig_d = (hb_q == '1);
   end

   // Next-state and burst checking; an accepted beat takes priority over timeout.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      timer_d    = timer_q;
      base_d     = base_q;
      err_d      = err_q;
      feb_d      = feb_q;
      data_out_d = data_out_q;
      timeout_d  = timeout_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d    = StRun;
               beat_d     = '0;
               timer_d    = '0;
               base_d     = base_pattern;
               err_d      = '0;
               feb_d      = '0;
               data_out_d = '0;
               timeout_d  = 1'b0;
            end
         end
         StRun: begin
            if (rd_valid) begin
               timer_d = '0;
               if (rd_data != exp_word) begin
                  if (err_q != '1) err_d = err_q + 1'b1;
                  if (err_q == '0) begin
                     data_out_d = rd_data;
                     feb_d      = beat_q;
                  end
               end else if (err_q == '0) begin
                  data_out_d = rd_data;
               end
               if (beat_q == BW'(BEATS - 1)) begin
                  state_d = StDone;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
               if (timer_d == TW'(TIMEOUT)) begin
                  timeout_d = 1'b1;
                  state_d   = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rd_ready       = (state_q == StRun);
   assign busy           = (state_q == StRun);
   assign done           = (state_q == StDone);
   assign pass           = done && (err_q == '0) && !timeout_q;
   assign timeout        = timeout_q;
   assign err_cnt        = err_q;
   assign first_err_beat = feb_q;
   assign data_out       = data_out_q;
   // r_led_q is low only while in reset; the failure indication pulls it low in DONE.
   assign r_led          = r_led_q && !(done && !pass);
   assign trigger        = trig_q;

endmodule

// File: tb/tb_ddr_rd_burst_checker.sv
// Directed bench for ddr_rd_burst_checker with default parameters.
module tb_ddr_rd_burst_checker;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [31:0]  base_pattern;
   logic         rd_valid;
   logic [255:0] rd_data;
   logic         rd_ready;
   logic         busy;
   logic         done;
   logic         pass;
   logic         timeout;
   logic [15:0]  err_cnt;
   logic [1:0]   first_err_beat;
   logic [255:0] data_out;
   logic         r_led;
   logic         trigger;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ddr_rd_burst_checker #(
      .DATA_W (256),
      .BEATS  (4),
      .CNT_W  (8),
      .TIMEOUT(1024),
      .ERR_W  (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_pattern  (base_pattern),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .rd_ready      (rd_ready),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .timeout       (timeout),
      .err_cnt       (err_cnt),
      .first_err_beat(first_err_beat),
      .data_out      (data_out),
      .r_led         (r_led),
      .trigger       (trigger)
   );

   function automatic logic [255:0] word(input logic [31:0] lane);
      return {8{lane}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_rd_ready"}, rd_ready, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_pass"}, pass, 0);
      chk({pfx, "_timeout"}, timeout, 0);
      chk({pfx, "_err_cnt"}, err_cnt, 0);
      chk({pfx, "_feb"}, first_err_beat, 0);
      chk({pfx, "_data_out"}, data_out, 0);
      chk({pfx, "_r_led"}, r_led, 0);
      chk({pfx, "_trigger"}, trigger, 0);
   endtask

   // One burst of 4 beats; bad_beat<0 means no corruption, tog inserts idle cycles,
   // poke pulses start (with another base) during RUN.
   task automatic burst(input logic [31:0] b, input int bad_beat, input bit tog,
                        input bit poke);
      start        = 1'b1;
      base_pattern = b;
      step();
      start = 1'b0;
      chk("run_busy", busy, 1);
      chk("run_ready", rd_ready, 1);
      for (int i = 0; i < 4; i++) begin
         if (tog) begin
            rd_valid = 1'b0;
            if (poke && i == 1) begin
               start        = 1'b1;
               base_pattern = 32'h5000;
            end
            step();
            start = 1'b0;
         end
         rd_valid = 1'b1;
         rd_data  = word(b + 32'(i));
         if (i == bad_beat) rd_data[0] = ~rd_data[0];
         if (i == 3) chk("pre_done", done, 0);
         step();
      end
      rd_valid = 1'b0;
   endtask

   initial begin
      reset        = 1'b0;
      start        = 1'b0;
      base_pattern = '0;
      rd_valid     = 1'b0;
      rd_data      = '0;
      repeat (3) step();
      chk_all_zero("rst");
      reset = 1'b1;
      step();

      // 1: clean burst
      burst(32'h1000, -1, 1'b0, 1'b0);
      chk("t1_done", done, 1);
      chk("t1_pass", pass, 1);
      chk("t1_err", err_cnt, 0);
      chk("t1_data", data_out, word(32'h1003));
      chk("t1_led", r_led, 1);
      chk("t1_busy", busy, 0);

      // 2: beat 2 lane 0 corrupted; restart from DONE
      burst(32'h1000, 2, 1'b0, 1'b0);
      chk("t2_done", done, 1);
      chk("t2_err", err_cnt, 1);
      chk("t2_feb", first_err_beat, 2);
      chk("t2_data", data_out, word(32'h1002) ^ 256'h1);
      chk("t2_pass", pass, 0);
      chk("t2_led", r_led, 0);

      // 3: 32-bit wrap of the pattern
      burst(32'hFFFF_FFFE, -1, 1'b0, 1'b0);
      chk("t3_pass", pass, 1);
      chk("t3_err", err_cnt, 0);
      chk("t3_feb", first_err_beat, 0);
      chk("t3_data", data_out, word(32'h0000_0001));

      // 4: no data -> timeout after TIMEOUT idle cycles
      start        = 1'b1;
      base_pattern = 32'h4000;
      step();
      start = 1'b0;
      repeat (1023) step();
      chk("t4_still_busy", busy, 1);
      chk("t4_no_to_yet", timeout, 0);
      step();
      chk("t4_done", done, 1);
      chk("t4_timeout", timeout, 1);
      chk("t4_pass", pass, 0);
      chk("t4_led", r_led, 0);
      burst(32'h4000, -1, 1'b0, 1'b0);
      chk("t4_to_clear", timeout, 0);
      chk("t4_pass2", pass, 1);

      // 5: gapped valid plus a start pulse during RUN that must be ignored
      burst(32'h2000, -1, 1'b1, 1'b1);
      chk("t5_done", done, 1);
      chk("t5_pass", pass, 1);
      chk("t5_data", data_out, word(32'h2003));
      rd_valid = 1'b1;
      rd_data  = word(32'h0BAD);
      repeat (2) step();
      rd_valid = 1'b0;
      chk("t5_hold_err", err_cnt, 0);
      chk("t5_hold_data", data_out, word(32'h2003));
      chk("t5_hold_done", done, 1);

      // 6: reset mid-burst, valid in IDLE, heartbeat period
      start        = 1'b1;
      base_pattern = 32'h3000;
      step();
      start    = 1'b0;
      rd_valid = 1'b1;
      rd_data  = word(32'h3000) ^ 256'h1;
      step();
      rd_data = word(32'h3001);
      step();
      chk("t6_mid_err", err_cnt, 1);
      chk("t6_mid_busy", busy, 1);
      reset    = 1'b0;
      rd_valid = 1'b0;
      step();
      chk_all_zero("t6_rst");
      reset    = 1'b1;
      rd_valid = 1'b1;
      rd_data  = word(32'hDEAD);
      for (int k = 1; k <= 512; k++) begin
         step();
         if (k == 3) begin
            chk("t6_idle_ready", rd_ready, 0);
            chk("t6_idle_busy", busy, 0);
            chk("t6_idle_err", err_cnt, 0);
            chk("t6_idle_data", data_out, 0);
            chk("t6_idle_led", r_led, 1);
            rd_valid = 1'b0;
         end
         if (k == 255) chk("t6_trig_255", trigger, 0);
         if (k == 256) chk("t6_trig_256", trigger, 1);
         if (k == 257) chk("t6_trig_257", trigger, 0);
         if (k == 511) chk("t6_trig_511", trigger, 0);
         if (k == 512) chk("t6_trig_512", trigger, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
